uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU's external data bus, clocked by `CLK_SYS`. It responds to stores and loads that the CPU's data-address decoder routes off-chip (`CS` = 0) inside a 16-byte window. Bytes written by the CPU are queued in a FIFO and serialized as 8N1 frames on `tx`. Read data is registered, so it is ready when the CPU's writeback stage selects `Data_BUS_READ`.

---
 rtl/uart_tx_mmio.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 UART transmitter on the CPU external data bus.
//            Stores to TXDATA are queued in a FIFO and serialized on tx; loads
//            return registered data one cycle after the access.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WE,
    output logic [31:0] Data_BUS_READ,
    output logic        tx
);

    localparam int                   c_ptr_w     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                   c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one   = c_ptr_w'(1);
    localparam logic [1:0]           c_reg_txd   = 2'd0;
    localparam logic [1:0]           c_reg_stat  = 2'd1;
    localparam logic [1:0]           c_reg_baud  = 2'd2;
    localparam logic [1:0]           c_reg_ctrl  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Architectural registers
    logic [15:0]        baud_q;
    logic               en_q;
    logic               ovf_q;
    logic [31:0]        rdata_q;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;

    // Serializer
    state_t             state_q;
    logic [7:0]         shift_q;
    logic [2:0]         bit_q;
    logic [15:0]        timer_q;
    logic [15:0]        div_lat_q;
    logic               tx_q;

    logic               w_sel;
    logic [1:0]         w_reg;
    logic               w_wr;
    logic               w_rd;
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_push_req;
    logic               w_push;
    logic               w_bit_end;
    logic               w_pop;
    logic [31:0]        w_rmux;
    logic               w_unused_bits;

    assign w_sel      = !CS && (ADDR[31:4] == BASE_ADDR[31:4]);
    assign w_reg      = ADDR[3:2];
    assign w_wr       = w_sel && WE;
    assign w_rd       = w_sel && !WE;
    assign w_full     = (count_q == c_depth);
    assign w_empty    = (count_q == '0);
    assign w_busy     = (state_q != S_IDLE);
    // Fullness is judged on the pre-edge count, so a pop in the same cycle
    // does not rescue a push into a full FIFO.
    assign w_push_req = w_wr && (w_reg == c_reg_txd);
    assign w_push     = w_push_req && !w_full;
    assign w_bit_end  = (timer_q == 16'd0);
    // A new frame starts either from idle or straight out of a finished stop bit.
    assign w_pop      = en_q && !w_empty &&
                        ((state_q == S_IDLE) || ((state_q == S_STOP) && w_bit_end));

    assign w_unused_bits = ^{ADDR[1:0], Data_BUS_WRITE[31:16]};

    assign Data_BUS_READ = rdata_q;
    assign tx            = tx_q;

    // Register read multiplexer
    always_comb begin
        w_rmux = 32'd0;
        case (w_reg)
            c_reg_stat: w_rmux = {24'd0, 4'(count_q), ovf_q, w_empty, w_full, w_busy};
            c_reg_baud: w_rmux = {16'd0, baud_q};
            c_reg_ctrl: w_rmux = {31'd0, en_q};
            default:    w_rmux = 32'd0;
        endcase
    end

    // Control registers, sticky overflow and registered load data
    always_ff @(posedge CLK) begin
        if (Reset) begin
            baud_q  <= DEFAULT_DIV;
            en_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= w_rd ? w_rmux : 32'd0;
            if (w_wr) begin
                case (w_reg)
                    c_reg_stat: if (Data_BUS_WRITE[3]) ovf_q <= 1'b0;
                    c_reg_baud: baud_q <= (Data_BUS_WRITE[15:0] == 16'd0) ? 16'd1
                                                                          : Data_BUS_WRITE[15:0];
                    c_reg_ctrl: en_q <= Data_BUS_WRITE[0];
                    default: ;
                endcase
            end
            if (w_push_req && w_full) ovf_q <= 1'b1;
        end
    end

    // FIFO data storage (no reset needed; validity tracked by count)
    always_ff @(posedge CLK) begin
        if (w_push) mem_q[wr_ptr_q] <= Data_BUS_WRITE[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_cnt_one;
                2'b01:   count_q <= count_q - c_cnt_one;
                default: ;
            endcase
        end
    end

    // Frame serializer: start, 8 data bits LSB first, stop; divisor latched per frame
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= 8'd0;
            bit_q     <= 3'd0;
            timer_q   <= 16'd0;
            div_lat_q <= DEFAULT_DIV;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                        shift_q   <= mem_q[rd_ptr_q];
                        div_lat_q <= baud_q;
                        timer_q   <= baud_q - 16'd1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= 3'd0;
                        timer_q <= div_lat_q - 16'd1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        timer_q <= div_lat_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            state_q   <= S_START;
                            tx_q      <= 1'b0;
                            shift_q   <= mem_q[rd_ptr_q];
                            div_lat_q <= baud_q;
                            timer_q   <= baud_q - 16'd1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Self-checking bench for uart_tx_mmio. Frames on tx are decoded
//            by sampling every cycle and compared with a queue-based model of
//            accepted bytes and expected register contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE     = 32'hFFFF_FF00;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_BAUD   = BASE + 32'h8;
    localparam logic [31:0] A_CTRL   = BASE + 32'hC;

    logic        CLK   = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] ADDR  = 32'd0;
    logic [31:0] DW    = 32'd0;
    logic        CS    = 1'b1;
    logic        WE    = 1'b0;
    logic [31:0] DR;
    logic        tx;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] st;
    logic [31:0] want;
    logic [7:0]  b;
    logic [7:0]  bm1, bm2, bm3;
    logic [7:0]  exp_q [$];
    logic [7:0]  cap_q [$];
    int          idle_q [$];
    bit          ok_q [$];
    bit          f1, f2;
    int          i1, i2;
    logic [7:0]  d1, d2;
    bit          ok1, ok2;
    int          mcnt;
    bit          movf;
    int          dv;
    int          gaps;

    always #5 CLK = ~CLK;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd434)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .ADDR          (ADDR),
        .Data_BUS_WRITE(DW),
        .CS            (CS),
        .WE            (WE),
        .Data_BUS_READ (DR),
        .tx            (tx)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_idle();
        CS   = 1'b1;
        WE   = 1'b0;
        ADDR = 32'd0;
        DW   = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        CS = 1'b0; WE = 1'b1; ADDR = a; DW = d;
        @(posedge CLK);
        #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        CS = 1'b0; WE = 1'b0; ADDR = a; DW = $urandom;
        @(posedge CLK);
        #1;
        d = DR;
        bus_idle();
    endtask

    // Waits (bounded) for a start bit, then records 10*div samples and decodes them.
    task automatic capture_frame(input int div, input int limit, output bit found,
                                 output int idle, output logic [7:0] data, output bit shape_ok);
        logic s [$];
        found = 1'b0; idle = 0; data = 8'd0; shape_ok = 1'b1;
        while (!found && idle < limit) begin
            @(posedge CLK);
            #1;
            if (tx === 1'b0) found = 1'b1;
            else idle++;
        end
        if (!found) begin
            shape_ok = 1'b0;
            return;
        end
        s.push_back(tx);
        for (int i = 1; i < 10 * div; i++) begin
            @(posedge CLK);
            #1;
            s.push_back(tx);
        end
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < div; j++)
                if (s[k * div + j] !== s[k * div]) shape_ok = 1'b0;
        if (s[0] !== 1'b0 || s[9 * div] !== 1'b1) shape_ok = 1'b0;
        for (int k = 0; k < 8; k++) data[k] = s[(k + 1) * div];
    endtask

    task automatic capture_all(input int div, input int first_limit, input int max_frames);
        bit         f;
        int         id;
        logic [7:0] d;
        bit         ok;
        cap_q.delete(); idle_q.delete(); ok_q.delete();
        for (int i = 0; i < max_frames; i++) begin
            capture_frame(div, (i == 0) ? first_limit : 10, f, id, d, ok);
            if (!f) break;
            cap_q.push_back(d); idle_q.push_back(id); ok_q.push_back(ok);
        end
    endtask

    task test_reset();
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (DR !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", DR); end
        bus_read(A_STATUS, st);
        n_cmp++; if (st !== 32'h04) begin n_fail++; $display("FAIL reset_status: got %h want 04", st); end
        bus_read(A_BAUD, st);
        n_cmp++; if (st !== 32'd434) begin n_fail++; $display("FAIL reset_baud: got %0d want 434", st); end
        bus_read(A_CTRL, st);
        n_cmp++; if (st !== 32'd1) begin n_fail++; $display("FAIL reset_ctrl: got %h want 1", st); end
        bus_read(A_TXDATA, st);
        n_cmp++; if (st !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", st); end
    endtask

    task test_single_frame();
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXDATA, 32'hA5);
        fork
            capture_frame(4, 20, f1, i1, d1, ok1);
            begin
                tick(10);
                bus_read(A_STATUS, st);
            end
        join
        n_cmp++; if (!f1 || i1 != 0) begin n_fail++; $display("FAIL single_latency: found=%0d idle=%0d want found=1 idle=0", f1, i1); end
        n_cmp++; if (d1 !== 8'hA5 || !ok1) begin n_fail++; $display("FAIL single_frame: got %h shape_ok=%0d want a5 shape_ok=1", d1, ok1); end
        n_cmp++; if (st !== 32'h05) begin n_fail++; $display("FAIL single_busy: got %h want 05", st); end
        tick(1);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_idle_tx: got %b want 1", tx); end
        bus_read(A_STATUS, st);
        n_cmp++; if (st !== 32'h04) begin n_fail++; $display("FAIL single_done: got %h want 04", st); end
    endtask

    task test_back_to_back();
        bus_write(A_BAUD, 32'd2);
        exp_q.delete();
        mcnt = 0;
        movf = 1'b0;
        fork
            begin
                for (int t = 0; t < 12; t++) begin
                    b = 8'($urandom);
                    bus_write(A_TXDATA, {24'd0, b});
                    if (mcnt == 8) movf = 1'b1;
                    else begin
                        exp_q.push_back(b);
                        mcnt++;
                    end
                    // The idle engine takes the first byte one cycle after it arrives.
                    if (t == 1) mcnt--;
                end
                want = 32'((mcnt << 4) | (movf ? 8 : 0) | ((mcnt == 0) ? 4 : 0) | ((mcnt == 8) ? 2 : 0) | 1);
                bus_read(A_STATUS, st);
                n_cmp++; if (st !== want) begin n_fail++; $display("FAIL b2b_status_ovf: got %h want %h", st, want); end
                bus_write(A_STATUS, 32'h8);
                want = want & ~32'h8;
                bus_read(A_STATUS, st);
                n_cmp++; if (st !== want) begin n_fail++; $display("FAIL b2b_ovf_clear: got %h want %h", st, want); end
            end
            capture_all(2, 10, 12);
        join
        n_cmp++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= cap_q.size()) begin
                n_fail++; $display("FAIL b2b_byte[%0d]: got none want %h", i, exp_q[i]);
            end else if (cap_q[i] !== exp_q[i] || !ok_q[i]) begin
                n_fail++; $display("FAIL b2b_byte[%0d]: got %h shape_ok=%0d want %h shape_ok=1", i, cap_q[i], ok_q[i], exp_q[i]);
            end
        end
        gaps = 0;
        for (int i = 1; i < cap_q.size(); i++) if (idle_q[i] != 0) gaps++;
        n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_gap: got %0d gapped frames want 0", gaps); end
    endtask

    task test_full_pop();
        bus_write(A_BAUD, 32'd2);
        bus_write(A_CTRL, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            bus_write(A_TXDATA, {24'd0, b});
            exp_q.push_back(b);
        end
        bus_read(A_STATUS, st);
        n_cmp++; if (st !== 32'h82) begin n_fail++; $display("FAIL full_status: got %h want 82", st); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL full_disabled_tx: got %b want 1", tx); end
        fork
            capture_all(2, 20, 10);
            begin
                bus_write(A_CTRL, 32'd1);
                bus_write(A_TXDATA, {24'd0, 8'($urandom)});
                bus_read(A_STATUS, st);
                n_cmp++; if (st !== 32'h79) begin n_fail++; $display("FAIL full_pop_drop: got %h want 79", st); end
                bus_write(A_STATUS, 32'h8);
                bus_read(A_STATUS, st);
                n_cmp++; if (st !== 32'h71) begin n_fail++; $display("FAIL full_ovf_clear: got %h want 71", st); end
            end
        join
        n_cmp++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL full_frame_count: got %0d want %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= cap_q.size()) begin
                n_fail++; $display("FAIL full_byte[%0d]: got none want %h", i, exp_q[i]);
            end else if (cap_q[i] !== exp_q[i] || !ok_q[i]) begin
                n_fail++; $display("FAIL full_byte[%0d]: got %h shape_ok=%0d want %h shape_ok=1", i, cap_q[i], ok_q[i], exp_q[i]);
            end
        end
    endtask

    task test_midframe_baud();
        bus_write(A_BAUD, 32'd4);
        bm1 = ($urandom & 1) ? 8'h5A : 8'hA5;
        bm2 = 8'($urandom);
        fork
            begin
                capture_frame(4, 20, f1, i1, d1, ok1);
                capture_frame(8, 20, f2, i2, d2, ok2);
            end
            begin
                bus_write(A_TXDATA, {24'd0, bm1});
                bus_write(A_TXDATA, {24'd0, bm2});
                tick(10);
                bus_write(A_BAUD, 32'd8);
            end
        join
        n_cmp++; if (!f1 || d1 !== bm1 || !ok1) begin n_fail++; $display("FAIL baud_frame1: got %h shape_ok=%0d want %h shape_ok=1", d1, ok1, bm1); end
        n_cmp++; if (!f2 || i2 != 0 || d2 !== bm2 || !ok2) begin n_fail++; $display("FAIL baud_frame2: got %h shape_ok=%0d idle=%0d want %h shape_ok=1 idle=0", d2, ok2, i2, bm2); end
    endtask

    task test_enable_clear();
        bus_write(A_BAUD, 32'd4);
        bm1 = 8'($urandom); bm2 = 8'($urandom); bm3 = 8'($urandom);
        fork
            begin
                capture_frame(4, 20, f1, i1, d1, ok1);
                capture_frame(4, 60, f2, i2, d2, ok2);
            end
            begin
                bus_write(A_TXDATA, {24'd0, bm1});
                bus_write(A_TXDATA, {24'd0, bm2});
                bus_write(A_TXDATA, {24'd0, bm3});
                tick(10);
                bus_read(A_STATUS, st);
                bus_write(A_CTRL, 32'd0);
            end
        join
        n_cmp++; if (st !== 32'h21) begin n_fail++; $display("FAIL en_pre_status: got %h want 21", st); end
        n_cmp++; if (!f1 || d1 !== bm1 || !ok1) begin n_fail++; $display("FAIL en_frame_done: got %h shape_ok=%0d want %h shape_ok=1", d1, ok1, bm1); end
        n_cmp++; if (f2) begin n_fail++; $display("FAIL en_no_pop: got frame %h want none", d2); end
        bus_read(A_STATUS, st);
        n_cmp++; if (st !== 32'h20) begin n_fail++; $display("FAIL en_post_status: got %h want 20", st); end
        bus_write(A_CTRL, 32'd1);
        capture_frame(4, 5, f1, i1, d1, ok1);
        capture_frame(4, 5, f2, i2, d2, ok2);
        n_cmp++; if (!f1 || i1 != 0 || d1 !== bm2 || !ok1) begin n_fail++; $display("FAIL en_resume1: got %h idle=%0d want %h idle=0", d1, i1, bm2); end
        n_cmp++; if (!f2 || i2 != 0 || d2 !== bm3 || !ok2) begin n_fail++; $display("FAIL en_resume2: got %h idle=%0d want %h idle=0", d2, i2, bm3); end
    endtask

    task test_random_div();
        bus_write(A_BAUD, 32'd0);
        bus_read(A_BAUD, st);
        n_cmp++; if (st !== 32'd1) begin n_fail++; $display("FAIL baud_zero: got %0d want 1", st); end
        b = 8'($urandom);
        bus_write(A_TXDATA, {24'd0, b});
        capture_frame(1, 5, f1, i1, d1, ok1);
        n_cmp++; if (!f1 || i1 != 0 || d1 !== b || !ok1) begin n_fail++; $display("FAIL div1_frame: got %h idle=%0d shape_ok=%0d want %h", d1, i1, ok1, b); end
        for (int it = 0; it < 5; it++) begin
            dv = $urandom_range(1, 5);
            bus_write(A_BAUD, 32'(dv));
            b = 8'($urandom);
            bus_write(A_TXDATA, {24'd0, b});
            capture_frame(dv, 5, f1, i1, d1, ok1);
            n_cmp++; if (!f1 || i1 != 0 || d1 !== b || !ok1) begin n_fail++; $display("FAIL rand_frame[%0d] div=%0d: got %h idle=%0d shape_ok=%0d want %h", it, dv, d1, i1, ok1, b); end
        end
        tick(2);
    endtask

    task test_decode_reset();
        bus_write(A_BAUD, 32'd4);
        CS = 1'b1; WE = 1'b1; ADDR = A_TXDATA; DW = 32'h55;
        tick(1);
        CS = 1'b1; WE = 1'b0; ADDR = A_BAUD;
        tick(1);
        n_cmp++; if (DR !== 32'd0) begin n_fail++; $display("FAIL cs_read: got %h want 0", DR); end
        bus_idle();
        bus_write(BASE + 32'h18, 32'd7);
        bus_write(BASE + 32'h1C, 32'd0);
        bus_read(BASE + 32'h14, st);
        n_cmp++; if (st !== 32'd0) begin n_fail++; $display("FAIL outside_read: got %h want 0", st); end
        bus_read(A_BAUD | 32'h3, st);
        n_cmp++; if (st !== 32'd4) begin n_fail++; $display("FAIL baud_untouched: got %0d want 4", st); end
        bus_read(A_CTRL, st);
        n_cmp++; if (st !== 32'd1) begin n_fail++; $display("FAIL ctrl_untouched: got %h want 1", st); end
        bus_read(A_STATUS, st);
        n_cmp++; if (st !== 32'h04) begin n_fail++; $display("FAIL decode_no_push: got %h want 04", st); end
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'h00);
        tick(8);
        n_cmp++; if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_data_tx: got %b want 0", tx); end
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_mid_tx: got %b want 1", tx); end
        bus_read(A_STATUS, st);
        n_cmp++; if (st !== 32'h04) begin n_fail++; $display("FAIL reset_mid_status: got %h want 04", st); end
        bus_read(A_BAUD, st);
        n_cmp++; if (st !== 32'd434) begin n_fail++; $display("FAIL reset_mid_baud: got %0d want 434", st); end
        capture_frame(4, 30, f1, i1, d1, ok1);
        n_cmp++; if (f1) begin n_fail++; $display("FAIL reset_mid_quiet: got frame %h want none", d1); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_pop();
        test_midframe_baud();
        test_enable_clear();
        test_random_div();
        test_decode_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
